// File: rtl/rf_mrmw_if.sv
// rf_mrmw_if: read, write and debug bus of the multi-port register file
interface rf_mrmw_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NR = 2,
    parameter int NW = 1
);
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic             ready;
    logic [AW-1:0]    dbg_addr;
    logic [DW-1:0]    dbg_data;
    modport master (output raddr, we, waddr, wdata, dbg_addr, input rdata, ready, dbg_data);
    modport slave (input raddr, we, waddr, wdata, dbg_addr, output rdata, ready, dbg_data);
endinterface

// File: rtl/rf_mrmw.sv
// rf_mrmw: parametrised NR-read/NW-write register file with bypass and post-reset clear
module rf_mrmw #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input logic       clock,
    input logic       reset,
    rf_mrmw_if.slave  bus
);
    localparam int DEPTH = 2**AW;
    typedef enum logic {CLEAR, RUN} state_t;
    state_t        state, state_nx;
    logic [AW-1:0] clr_idx, clr_idx_nx;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nx;
            clr_idx <= clr_idx_nx;
        end
    end
    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        if (state == CLEAR) begin
            clr_idx_nx = clr_idx + 1'b1;
            state_nx   = &clr_idx ? RUN : CLEAR;
        end
    end
    // ascending port order lets the highest-indexed write win on an address clash
    always_ff @(posedge clock) begin
        if (state == CLEAR)
            mem[clr_idx] <= '0;
        else if (!reset)
            for (int w = 0; w < NW; w++)
                if (bus.we[w] && !(ZERO_REG != 0 && bus.waddr[w*AW +: AW] == '0))
                    mem[bus.waddr[w*AW +: AW]] <= bus.wdata[w*DW +: DW];
    end
    always_comb begin
        bus.rdata = '0;
        ra        = '0;
        rd        = '0;
        for (int r = 0; r < NR; r++) begin
            ra = bus.raddr[r*AW +: AW];
            rd = mem[ra];
            if (BYPASS != 0)
                for (int w = 0; w < NW; w++)
                    if (bus.we[w] && bus.waddr[w*AW +: AW] == ra)
                        rd = bus.wdata[w*DW +: DW];
            bus.rdata[r*DW +: DW] = (state != RUN || (ZERO_REG != 0 && ra == '0)) ? '0 : rd;
        end
    end
    assign bus.ready    = (state == RUN);
    assign bus.dbg_data = (state == RUN) ? mem[bus.dbg_addr] : '0;
endmodule
